aib_avmm_cfg_rsp: RTL and testbench

// - Avalon-MM responder (slave) for the 32-bit config bus driven by the bench avmm agent.
// - Holds a word-addressed config register file.
// - Drives the flattened register contents as static config to the AIB channel logic.
// - Returns read data with a fixed, parameterised latency.

---
 rtl/aib_avmm_cfg_rsp_if.sv | 23 ++
 rtl/aib_avmm_cfg_rsp.sv | 210 +++++++++++++++++++++
 tb/tb_aib_avmm_cfg_rsp.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aib_avmm_cfg_rsp_if.sv
// Avalon-MM config bus between the avmm agent (master) and the config responder (slave).
interface aib_avmm_cfg_rsp_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] avmm_address;
  logic                  avmm_write;
  logic                  avmm_read;
  logic [3:0]            avmm_byteenable;
  logic [31:0]           avmm_writedata;
  logic [31:0]           avmm_readdata;
  logic                  avmm_readdatavalid;
  logic                  avmm_waitrequest;

  modport master (
    output avmm_address, avmm_write, avmm_read, avmm_byteenable, avmm_writedata,
    input  avmm_readdata, avmm_readdatavalid, avmm_waitrequest
  );

  modport slave (
    input  avmm_address, avmm_write, avmm_read, avmm_byteenable, avmm_writedata,
    output avmm_readdata, avmm_readdatavalid, avmm_waitrequest
  );
endinterface

// File: rtl/aib_avmm_cfg_rsp.sv
// Avalon-MM config register responder: zero-wait writes, fixed-latency reads, flattened static config out.
// Optional AIB_AVMM_RSP_ERR_EN adds o_avmm_response and o_wr_slverr error reporting.
module aib_avmm_cfg_rsp #(
  parameter int          ADDR_WIDTH = 17,
  parameter int          NUM_REGS   = 16,
  parameter int          RD_LAT     = 2,
  parameter logic [31:0] RST_VAL    = 32'h0000_0000
) (
  input  logic                     avmm_clk,
  input  logic                     avmm_rst_n,
  aib_avmm_cfg_rsp_if.slave        avmm,
  output logic [NUM_REGS*32-1:0]   o_cfg,
`ifdef AIB_AVMM_RSP_ERR_EN
  output logic [1:0]               o_avmm_response,
  output logic                     o_wr_slverr,
`endif
  output logic                     o_cmd_err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RD_RESP = 2'b10
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [31:0]            regs_r [NUM_REGS];
  logic [NUM_REGS*32-1:0] cfg_s, cfg_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SEL_W-1:0]       rd_sel_r;
  logic                   rd_oor_r;
  logic                   wait_r, wait_nxt_s;
  logic                   rdv_r, rdv_nxt_s;
  logic [31:0]            rdata_r, rdata_nxt_s;
  logic                   cmd_err_r, cmd_err_nxt_s;
  logic [IDX_W-1:0]       idx_s;
  logic [SEL_W-1:0]       sel_s;
  logic                   in_range_s, accept_s, wr_acc_s, rd_acc_s, rw_both_s;

  assign idx_s      = avmm.avmm_address[ADDR_WIDTH-1:2];
  assign sel_s      = idx_s[SEL_W-1:0];
  assign in_range_s = (32'(idx_s) < 32'(NUM_REGS));
  // A held waitrequest (reset or read in flight) masks the command entirely.
  assign accept_s   = (state_r == IDLE) && !wait_r && (avmm.avmm_read || avmm.avmm_write);
  assign wr_acc_s   = accept_s && avmm.avmm_write;
  assign rd_acc_s   = accept_s && avmm.avmm_read && !avmm.avmm_write;
  assign rw_both_s  = accept_s && avmm.avmm_read && avmm.avmm_write;

  // FSM state register
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (rd_acc_s) begin
          state_nxt_s = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = RD_RESP;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RD_RESP: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered bus outputs
  always_comb begin
    wait_nxt_s    = 1'b1;
    rdv_nxt_s     = 1'b0;
    rdata_nxt_s   = 32'h0000_0000;
    cmd_err_nxt_s = cmd_err_r;
    case (state_r)
      IDLE: begin
        wait_nxt_s = rd_acc_s;
        if (rw_both_s || (wr_acc_s && !in_range_s)) begin
          cmd_err_nxt_s = 1'b1;
        end else begin
          cmd_err_nxt_s = cmd_err_r;
        end
      end
      RD_WAIT: wait_nxt_s = 1'b1;
      RD_RESP: begin
        rdv_nxt_s = 1'b1;
        if (rd_oor_r) begin
          rdata_nxt_s   = 32'h0000_0000;
          cmd_err_nxt_s = 1'b1;
        end else begin
          rdata_nxt_s   = regs_r[rd_sel_r];
          cmd_err_nxt_s = cmd_err_r;
        end
      end
      default: wait_nxt_s = 1'b1;
    endcase
  end

  // Registered bus outputs and sticky error
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      wait_r    <= 1'b1;
      rdv_r     <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      cmd_err_r <= 1'b0;
    end else begin
      wait_r    <= wait_nxt_s;
      rdv_r     <= rdv_nxt_s;
      rdata_r   <= rdata_nxt_s;
      cmd_err_r <= cmd_err_nxt_s;
    end
  end

  // Read context: latched index and latency counter
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      rd_sel_r <= {SEL_W{1'b0}};
      rd_oor_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (rd_acc_s) begin
        rd_sel_r <= sel_s;
        rd_oor_r <= !in_range_s;
      end else begin
        rd_sel_r <= rd_sel_r;
        rd_oor_r <= rd_oor_r;
      end
      if (state_r == RD_WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Register file with byte-lane writes
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RST_VAL;
      end
    end else if (wr_acc_s && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (avmm.avmm_byteenable[b]) begin
          regs_r[sel_s][8*b +: 8] <= avmm.avmm_writedata[8*b +: 8];
        end
      end
    end
  end

  // Flatten the register file for the config output
  always_comb begin
    cfg_s = {(NUM_REGS*32){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_s[32*i +: 32] = regs_r[i];
    end
  end

  // Config output register, one edge behind the register file
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      cfg_r <= {NUM_REGS{RST_VAL}};
    end else begin
      cfg_r <= cfg_s;
    end
  end

`ifdef AIB_AVMM_RSP_ERR_EN
  logic [1:0] resp_r;
  logic       wr_slverr_r;

  // Read response code and out-of-range write pulse
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      resp_r      <= 2'b00;
      wr_slverr_r <= 1'b0;
    end else begin
      resp_r      <= ((state_r == RD_RESP) && rd_oor_r) ? 2'b10 : 2'b00;
      wr_slverr_r <= wr_acc_s && !in_range_s;
    end
  end

  assign o_avmm_response = resp_r;
  assign o_wr_slverr     = wr_slverr_r;
`endif

  assign avmm.avmm_waitrequest   = wait_r;
  assign avmm.avmm_readdatavalid = rdv_r;
  assign avmm.avmm_readdata      = rdata_r;
  assign o_cfg                   = cfg_r;
  assign o_cmd_err               = cmd_err_r;

endmodule

// File: tb/tb_aib_avmm_cfg_rsp.sv
// Self-checking bench for aib_avmm_cfg_rsp: cycle model of the bus contract plus directed literal checks.
module tb_aib_avmm_cfg_rsp;
  localparam int AW = 17;
  localparam int NR = 16;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR*32-1:0] cfg;
  logic            cmd_err;
`ifdef AIB_AVMM_RSP_ERR_EN
  logic [1:0]      resp;
  logic            wr_slverr;
  logic [1:0]      last_resp;
`endif

  aib_avmm_cfg_rsp_if #(.ADDR_WIDTH(AW)) bus ();

  aib_avmm_cfg_rsp #(
    .ADDR_WIDTH(AW), .NUM_REGS(NR), .RD_LAT(RL), .RST_VAL(32'h0000_0000)
  ) dut (
    .avmm_clk        (clk),
    .avmm_rst_n      (rst_n),
    .avmm            (bus),
    .o_cfg           (cfg),
`ifdef AIB_AVMM_RSP_ERR_EN
    .o_avmm_response (resp),
    .o_wr_slverr     (wr_slverr),
`endif
    .o_cmd_err       (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: what the outputs must be after the most recent posedge
  logic [31:0] m_regs [NR];
  logic [31:0] m_cfg  [NR];
  logic        m_err, m_wait, m_rdv, m_wslv, rd_oor;
  logic [31:0] m_rdata, rd_val;
  logic [1:0]  m_resp;
  int          rd_k, cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cfg(input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg actual=%h expected=%h", act, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] flat_cfg();
    logic [NR*32-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = m_cfg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = 32'h0;
      m_cfg[i]  = 32'h0;
    end
    m_err = 1'b0; m_wait = 1'b1; m_rdv = 1'b0; m_wslv = 1'b0; rd_oor = 1'b0;
    m_rdata = 32'h0; rd_val = 32'h0; m_resp = 2'b00; rd_k = -1; cyc = 0;
  endtask

  task automatic model_step(input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
    int   idx;
    logic inr, acc;
    cyc++;
    for (int i = 0; i < NR; i++) m_cfg[i] = m_regs[i];
    acc    = !m_wait && (rd || wr);
    idx    = int'(addr >> 2);
    inr    = (idx < NR);
    m_wslv = 1'b0;
    if (acc && wr) begin
      if (inr) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        m_err  = 1'b1;
        m_wslv = 1'b1;
      end
      if (rd) m_err = 1'b1;
    end else if (acc && rd) begin
      rd_k   = cyc;
      rd_oor = !inr;
      if (inr) rd_val = m_regs[idx];
      else     rd_val = 32'h0;
    end
    m_rdv   = (rd_k >= 0) && (cyc == rd_k + RL);
    m_rdata = m_rdv ? rd_val : 32'h0;
    m_resp  = (m_rdv && rd_oor) ? 2'b10 : 2'b00;
    if (m_rdv && rd_oor) m_err = 1'b1;
    m_wait  = (rd_k >= 0) && (cyc <= rd_k + RL);
    if ((rd_k >= 0) && (cyc > rd_k + RL)) rd_k = -1;
  endtask

  // Compare DUT against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("waitrequest", bus.avmm_waitrequest, m_wait);
      chk("readdatavalid", bus.avmm_readdatavalid, m_rdv);
      chk("readdata", bus.avmm_readdata, m_rdata);
      chk("cmd_err", cmd_err, m_err);
      chk_cfg(cfg, flat_cfg());
`ifdef AIB_AVMM_RSP_ERR_EN
      if (m_rdv) chk("response", resp, m_resp);
      chk("wr_slverr", wr_slverr, m_wslv);
`endif
    end
  end

  task automatic cycle(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    bus.avmm_read = rd; bus.avmm_write = wr; bus.avmm_address = addr;
    bus.avmm_byteenable = be; bus.avmm_writedata = wd;
    @(posedge clk);
    model_step(rd, wr, addr, be, wd);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 17'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
    cycle(1'b0, 1'b1, addr, be, wd);
  endtask

  // Single-cycle read request, then a bounded watch for the response
  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data,
                         output int lat, output int wcnt);
    lat = -1; wcnt = 0; data = 32'h0;
    for (int n = 0; n < 10; n++) begin
      if (n == 0) cycle(1'b1, 1'b0, addr, 4'h0, 32'h0);
      else        idle(1);
      if (bus.avmm_waitrequest) wcnt++;
      if (bus.avmm_readdatavalid && (lat < 0)) begin
        lat  = n;
        data = bus.avmm_readdata;
`ifdef AIB_AVMM_RSP_ERR_EN
        last_resp = resp;
`endif
      end
    end
  endtask

  task automatic rst_assert();
    rst_n = 1'b0;
    bus.avmm_read = 1'b0; bus.avmm_write = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] d;
  int lat, wc;

  initial begin
    bus.avmm_read = 1'b0; bus.avmm_write = 1'b0; bus.avmm_address = '0;
    bus.avmm_byteenable = 4'h0; bus.avmm_writedata = 32'h0;
`ifdef AIB_AVMM_RSP_ERR_EN
    last_resp = 2'b00;
`endif
    #2;
    rst_assert();
    chk_en = 1'b1;
    chk("rst_wait", bus.avmm_waitrequest, 1'b1);
    chk("rst_rdv", bus.avmm_readdatavalid, 1'b0);
    chk("rst_cfg", {63'h0, |cfg}, 64'h0);
    rst_n = 1'b1;
    idle(1);
    chk("wait_drop", bus.avmm_waitrequest, 1'b0);

    // Full-word write then RD_LAT=2 read
    wr(17'h08, 4'hF, 32'hA5A5_1234);
    do_read(17'h08, d, lat, wc);
    chk("rd08_data", d, 32'hA5A5_1234);
    chk("rd08_lat", lat, 2);
    chk("rd08_wait_cycles", wc, 3);

    // Byte lanes: clear lanes 0 and 2, then an empty byteenable
    wr(17'h04, 4'hF, 32'hFFFF_FFFF);
    wr(17'h04, 4'b0101, 32'h0000_0000);
    do_read(17'h04, d, lat, wc);
    chk("rd04_lanes", d, 32'hFF00_FF00);
    wr(17'h04, 4'b0000, 32'h1234_5678);
    do_read(17'h04, d, lat, wc);
    chk("rd04_be0", d, 32'hFF00_FF00);

    // Back-to-back writes to every register, byte-offset bits ignored
    for (int i = 0; i < NR; i++) wr(AW'(i*4 + (i%4)), 4'hF, 32'h1000_0000 + 32'(i));
    idle(1);
    chk("cfg_top", cfg[NR*32-1 -: 32], 32'h1000_000F);
    do_read(17'h3C, d, lat, wc);
    chk("rd_last", d, 32'h1000_000F);
    chk("no_err", cmd_err, 1'b0);

    // Out-of-range write and read
    rst_assert(); rst_n = 1'b1; idle(1);
    wr(17'h40, 4'hF, 32'h0000_0001);
    idle(1);
    chk("oor_wr_err", cmd_err, 1'b1);
    chk("oor_wr_cfg", {63'h0, |cfg}, 64'h0);
    do_read(17'h40, d, lat, wc);
    chk("oor_rd_data", d, 32'h0);
    chk("oor_rd_lat", lat, 2);
`ifdef AIB_AVMM_RSP_ERR_EN
    chk("oor_rd_resp", last_resp, 2'b10);
`endif

    // Simultaneous read and write acts as a write only
    rst_assert(); rst_n = 1'b1; idle(1);
    cycle(1'b1, 1'b1, 17'h00, 4'hF, 32'h0000_0005);
    idle(4);
    chk("rw_reg0", cfg[31:0], 32'h0000_0005);
    chk("rw_err", cmd_err, 1'b1);

    // Reset one cycle after a read is accepted
    rst_assert(); rst_n = 1'b1; idle(1);
    wr(17'h0C, 4'hF, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 17'h0C, 4'h0, 32'h0);
    idle(1);
    rst_assert();
    chk("mr_wait", bus.avmm_waitrequest, 1'b1);
    chk("mr_rdv", bus.avmm_readdatavalid, 1'b0);
    chk("mr_cfg", {63'h0, |cfg}, 64'h0);
    rst_n = 1'b1;
    idle(4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
